ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
Pipeline register between the ALU (EX) and the data-memory stage (MEM) of the pipelined MIPS core. Captures the ALU result, flags, store data and control each cycle, and provides a forwarding source back to EX. Detects signed add/sub overflow, converts the offending instruction into a bubble, and raises a precise exception with the EPC. Squashes further instructions until the exception is acknowledged.

Parameters:
DATA_W, 32, datapath width (result, store data, PC)
REG_AW, 5, register-file address width
CNT_W, 8, width of the saturating overflow-event counter

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
iValid  input  1  EX slot holds a real instruction
iStall  input  1  hold all stage registers (MEM-side stall)
iFlush  input  1  load a bubble this cycle (branch/jump squash)
iALUResult  input  DATA_W  ALU oS
iALUZ  input  1  ALU oZ
iALUV  input  1  ALU oV
iALUN  input  1  ALU oN
iALUFun  input  6  ALU function code of the EX instruction
iSign  input  1  signed operation
iPC  input  DATA_W  PC of the EX instruction
iRtData  input  DATA_W  store data (forwarded rt)
iRegDst  input  REG_AW  destination register
iRegWrite  input  1  write-back enable
iMemRead  input  1  load
iMemWrite  input  1  store
iMemToReg  input  2  write-back source select
iExcAck  input  1  exception handler has taken the trap
oValid  output  1  MEM slot valid
oALUResult  output  DATA_W  registered result / memory address
oZ  output  1  registered zero flag
oN  output  1  registered negative flag
oRtData  output  DATA_W  registered store data
oRegDst  output  REG_AW  registered destination
oRegWrite, oMemRead, oMemWrite  output  1 each  registered controls, forced 0 when bubble
oMemToReg  output  2  registered select
oFwdValid  output  1  oValid & oRegWrite & (oRegDst != 0), combinational from registers
oOvfExc  output  1  one-cycle overflow exception pulse
oEPC  output  DATA_W  PC of the faulting instruction
oExcPending  output  1  high while in state EXC_WAIT
oOvfCount  output  CNT_W  saturating count of overflow events

Behaviour:
- Reset: all outputs and registers 0; state RUN. Reset mid-operation aborts any EXC_WAIT immediately.
- Latency: one cycle; inputs sampled on rising edge, visible the following cycle.
- Load priority per edge: flush > stall > exception squash > normal load.
- iFlush: load a bubble (oValid=0, oRegWrite/oMemRead/oMemWrite=0, data fields 0), even when iStall=1.
- iStall (no flush): every register holds, including state, counter and oEPC. oOvfExc is 0 during stall. Overflow detection is inhibited.
- Overflow condition ovf = iValid & !iStall & !iFlush & state==RUN & iSign & iALUV & (iALUFun==6'b000000 | iALUFun==6'b000001).
- On ovf: load a bubble; oOvfExc=1 for exactly one cycle; oEPC<=iPC; oOvfCount+=1, saturating at 2^CNT_W-1; state->EXC_WAIT.
- Unsigned add/sub (iSign=0) and all other ALUFun codes never trap. oV is not propagated.
- Normal load: all fields copied; oValid<=iValid; controls ANDed with iValid.
- State RUN: normal operation.
- State EXC_WAIT: every non-stalled edge loads a bubble, so younger instructions are squashed. oExcPending=1. oEPC holds.
- iExcAck in EXC_WAIT (not stalled): state->RUN; that same edge still loads a bubble. The next edge loads normally.
- iExcAck in RUN is ignored.
- Ack with stall: ignored until a non-stalled edge.

Test Plan:
- Reset mid-stream: drive a valid add, assert reset asynchronously between edges -> all outputs 0 immediately; oValid=0, state RUN.
- Pipelined flow: 3 back-to-back valid ops with results 0x1, 0x2, 0x3 and RegDst 8, 9, 0 -> results appear one cycle later in order; oFwdValid=1, 1, 0.
- Stall/flush priority: valid op 0xAA loaded, then iStall=1 for 2 cycles with new input 0xBB -> oALUResult stays 0xAA. Then iStall=1 with iFlush=1 -> oValid=0 and controls 0.
- Signed overflow trap: iALUFun=000000, iSign=1, iALUV=1, iPC=0x0040_0010, iRegWrite=1 -> next cycle oValid=0, oRegWrite=0, oOvfExc=1 for one cycle, oEPC=0x0040_0010, oOvfCount=1, oExcPending=1. Two further valid inputs -> bubbles. iExcAck=1 -> bubble that edge, then a normal load with oExcPending=0.
- No trap cases: same overflow with iSign=0, or with iALUFun=011000 and iALUV=1 -> instruction passes with oRegWrite=1 and oOvfExc=0.
- Counter saturation (CNT_W=2): 4 trap/ack sequences -> oOvfCount reads 1, 2, 3, 3.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side inputs (i*) and MEM-side/forwarding/exception outputs (o*).
// The master modport drives the stage. The slave modport is the stage itself.
interface ex_mem_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 8
);
    logic              iValid;
    logic              iStall;
    logic              iFlush;
    logic [DATA_W-1:0] iALUResult;
    logic              iALUZ;
    logic              iALUV;
    logic              iALUN;
    logic [5:0]        iALUFun;
    logic              iSign;
    logic [DATA_W-1:0] iPC;
    logic [DATA_W-1:0] iRtData;
    logic [REG_AW-1:0] iRegDst;
    logic              iRegWrite;
    logic              iMemRead;
    logic              iMemWrite;
    logic [1:0]        iMemToReg;
    logic              iExcAck;

    logic              oValid;
    logic [DATA_W-1:0] oALUResult;
    logic              oZ;
    logic              oN;
    logic [DATA_W-1:0] oRtData;
    logic [REG_AW-1:0] oRegDst;
    logic              oRegWrite;
    logic              oMemRead;
    logic              oMemWrite;
    logic [1:0]        oMemToReg;
    logic              oFwdValid;
    logic              oOvfExc;
    logic [DATA_W-1:0] oEPC;
    logic              oExcPending;
    logic [CNT_W-1:0]  oOvfCount;

    modport master (
        output iValid, iStall, iFlush, iALUResult, iALUZ, iALUV, iALUN, iALUFun, iSign,
               iPC, iRtData, iRegDst, iRegWrite, iMemRead, iMemWrite, iMemToReg, iExcAck,
        input  oValid, oALUResult, oZ, oN, oRtData, oRegDst, oRegWrite, oMemRead,
               oMemWrite, oMemToReg, oFwdValid, oOvfExc, oEPC, oExcPending, oOvfCount
    );

    modport slave (
        input  iValid, iStall, iFlush, iALUResult, iALUZ, iALUV, iALUN, iALUFun, iSign,
               iPC, iRtData, iRegDst, iRegWrite, iMemRead, iMemWrite, iMemToReg, iExcAck,
        output oValid, oALUResult, oZ, oN, oRtData, oRegDst, oRegWrite, oMemRead,
               oMemWrite, oMemToReg, oFwdValid, oOvfExc, oEPC, oExcPending, oOvfCount
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with signed add/sub overflow trapping.
// A trapping instruction becomes a bubble, and younger instructions are squashed until the trap is acked.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 8
) (
    input logic           clk,
    input logic           reset,
    ex_mem_stage_if.slave bus
);
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] EXC_WAIT = 1'b1;

    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_SUB = 6'b000001;

    logic              validQ,     validD;
    logic [DATA_W-1:0] resultQ,    resultD;
    logic              zQ,         zD;
    logic              nQ,         nD;
    logic [DATA_W-1:0] rtDataQ,    rtDataD;
    logic [REG_AW-1:0] regDstQ,    regDstD;
    logic              regWriteQ,  regWriteD;
    logic              memReadQ,   memReadD;
    logic              memWriteQ,  memWriteD;
    logic [1:0]        memToRegQ,  memToRegD;
    logic              ovfExcQ,    ovfExcD;
    logic [DATA_W-1:0] epcQ,       epcD;
    logic [CNT_W-1:0]  ovfCountQ,  ovfCountD;
    logic [0:0]        stateQ,     stateD;

    logic isAddSub;
    logic ovf;
    logic loadBubble;

    assign isAddSub = (bus.iALUFun == FUN_ADD) || (bus.iALUFun == FUN_SUB);

    assign ovf = bus.iValid && !bus.iStall && !bus.iFlush && (stateQ == RUN) &&
                 bus.iSign && bus.iALUV && isAddSub;

    // A flush wins even over a stall; otherwise a trap or a pending trap squashes the slot.
    assign loadBubble = bus.iFlush || (!bus.iStall && (ovf || (stateQ == EXC_WAIT)));

    always_comb begin
        validD    = validQ;
        resultD   = resultQ;
        zD        = zQ;
        nD        = nQ;
        rtDataD   = rtDataQ;
        regDstD   = regDstQ;
        regWriteD = regWriteQ;
        memReadD  = memReadQ;
        memWriteD = memWriteQ;
        memToRegD = memToRegQ;
        if (loadBubble) begin
            validD    = 1'b0;
            resultD   = '0;
            zD        = 1'b0;
            nD        = 1'b0;
            rtDataD   = '0;
            regDstD   = '0;
            regWriteD = 1'b0;
            memReadD  = 1'b0;
            memWriteD = 1'b0;
            memToRegD = '0;
        end else if (!bus.iStall) begin
            validD    = bus.iValid;
            resultD   = bus.iALUResult;
            zD        = bus.iALUZ;
            nD        = bus.iALUN;
            rtDataD   = bus.iRtData;
            regDstD   = bus.iRegDst;
            regWriteD = bus.iRegWrite && bus.iValid;
            memReadD  = bus.iMemRead && bus.iValid;
            memWriteD = bus.iMemWrite && bus.iValid;
            memToRegD = bus.iMemToReg;
        end
    end

    // Exception bookkeeping only advances on non-stalled edges, so an ack under stall waits.
    always_comb begin
        stateD    = stateQ;
        epcD      = epcQ;
        ovfCountD = ovfCountQ;
        ovfExcD   = ovf;
        if (!bus.iStall) begin
            if (ovf) begin
                stateD    = EXC_WAIT;
                epcD      = bus.iPC;
                ovfCountD = (ovfCountQ == {CNT_W{1'b1}}) ? ovfCountQ : ovfCountQ + CNT_W'(1);
            end else if ((stateQ == EXC_WAIT) && bus.iExcAck) begin
                stateD = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validQ    <= 1'b0;
            resultQ   <= '0;
            zQ        <= 1'b0;
            nQ        <= 1'b0;
            rtDataQ   <= '0;
            regDstQ   <= '0;
            regWriteQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            memToRegQ <= '0;
            ovfExcQ   <= 1'b0;
            epcQ      <= '0;
            ovfCountQ <= '0;
            stateQ    <= RUN;
        end else begin
            validQ    <= validD;
            resultQ   <= resultD;
            zQ        <= zD;
            nQ        <= nD;
            rtDataQ   <= rtDataD;
            regDstQ   <= regDstD;
            regWriteQ <= regWriteD;
            memReadQ  <= memReadD;
            memWriteQ <= memWriteD;
            memToRegQ <= memToRegD;
            ovfExcQ   <= ovfExcD;
            epcQ      <= epcD;
            ovfCountQ <= ovfCountD;
            stateQ    <= stateD;
        end
    end

    assign bus.oValid      = validQ;
    assign bus.oALUResult  = resultQ;
    assign bus.oZ          = zQ;
    assign bus.oN          = nQ;
    assign bus.oRtData     = rtDataQ;
    assign bus.oRegDst     = regDstQ;
    assign bus.oRegWrite   = regWriteQ;
    assign bus.oMemRead    = memReadQ;
    assign bus.oMemWrite   = memWriteQ;
    assign bus.oMemToReg   = memToRegQ;
    assign bus.oFwdValid   = validQ && regWriteQ && (regDstQ != '0);
    assign bus.oOvfExc     = ovfExcQ;
    assign bus.oEPC        = epcQ;
    assign bus.oExcPending = (stateQ == EXC_WAIT);
    assign bus.oOvfCount   = ovfCountQ;
endmodule
